// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: mode encodings, default maximal
// tap masks and a parameter legality check used at elaboration.
package lfsr_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  // Maximal-length Fibonacci masks (feedback = XOR of state & mask)
  localparam logic [3:0]  TAPS_FIB_W4  = 4'h9;
  localparam logic [7:0]  TAPS_FIB_W8  = 8'hB8;
  localparam logic [15:0] TAPS_FIB_W16 = 16'hB400;
  localparam logic [31:0] TAPS_FIB_W32 = 32'h8020_0003;

  // Maximal-length Galois masks (XORed in when the outgoing MSB is 1)
  localparam logic [3:0]  TAPS_GAL_W4  = 4'h3;
  localparam logic [7:0]  TAPS_GAL_W8  = 8'h1D;
  localparam logic [15:0] TAPS_GAL_W16 = 16'h002D;
  localparam logic [31:0] TAPS_GAL_W32 = 32'h0000_00C5;

  // Width in range, Fibonacci top tap set, Galois bit-0 tap set and a
  // nonzero reset seed: together these keep the all-zero state unreachable.
  function automatic logic taps_legal(input int unsigned w,
                                      input logic [31:0] fib,
                                      input logic [31:0] gal,
                                      input logic [31:0] seed);
    logic [31:0] mask;
    if (w < 3 || w > 32) return 1'b0;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return fib[w-1] && gal[0] && ((seed & mask) != 32'd0);
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function for one LFSR step in either
// Fibonacci or Galois form.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS_FIB = 16'hB400,
  parameter logic [WIDTH-1:0] TAPS_GAL = 16'h002D
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o
);

  // Shift left; Fibonacci feeds parity into bit 0, Galois folds taps on MSB out
  always_comb begin
    next_o = '0;
    if (mode_i == MODE_GAL) begin
      next_o = {state_i[WIDTH-2:0], 1'b0} ^ (state_i[WIDTH-1] ? TAPS_GAL : '0);
    end else begin
      next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS_FIB)};
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with Fibonacci/Galois mode, seed load, zero-seed
// replacement and on-line period measurement against a reference seed.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS_FIB   = 16'hB400,
  parameter logic [WIDTH-1:0] TAPS_GAL   = 16'h002D,
  parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             mode,
  output logic             q,
  output logic [WIDTH-1:0] state,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] step_cnt,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  if (!taps_legal(WIDTH, 32'(TAPS_FIB), 32'(TAPS_GAL), 32'(RESET_SEED))) begin : g_bad_params
    $error("lfsr_gen: illegal WIDTH, tap mask or RESET_SEED");
  end

  logic [WIDTH-1:0] state_q,  state_d;
  logic [WIDTH-1:0] ref_q,    ref_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             pvld_q,   pvld_d;
  logic             wrap_q,   wrap_d;
  logic             lock_q,   lock_d;
  logic             mode_q,   mode_d;
  logic [WIDTH-1:0] step_nxt;

  // The step always uses the live mode input: it equals mode_q unless a
  // mode change is being taken on this edge, which must use the new mode.
  lfsr_next #(
    .WIDTH    (WIDTH),
    .TAPS_FIB (TAPS_FIB),
    .TAPS_GAL (TAPS_GAL)
  ) u_next (
    .state_i (state_q),
    .mode_i  (mode),
    .next_o  (step_nxt)
  );

  // Next-state selection: load beats step; a mode change re-references the sequence
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pvld_d   = pvld_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    lock_d   = 1'b0;
    if (load) begin
      if (seed != '0) begin
        state_d = seed;
        ref_d   = seed;
      end else begin
        state_d = RESET_SEED;
        ref_d   = RESET_SEED;
        lock_d  = 1'b1;
      end
      cnt_d  = '0;
      pvld_d = 1'b0;
      mode_d = mode;
    end else if (en) begin
      state_d = step_nxt;
      if (mode != mode_q) begin
        ref_d  = state_q;
        cnt_d  = ONE;
        pvld_d = 1'b0;
        mode_d = mode;
      end else if (step_nxt == ref_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_q + ONE;
        pvld_d   = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // Register bank with synchronous reset to the reset seed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RESET_SEED;
      ref_q    <= RESET_SEED;
      cnt_q    <= '0;
      period_q <= '0;
      pvld_q   <= 1'b0;
      wrap_q   <= 1'b0;
      lock_q   <= 1'b0;
      mode_q   <= mode;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvld_q   <= pvld_d;
      wrap_q   <= wrap_d;
      lock_q   <= lock_d;
      mode_q   <= mode_d;
    end
  end

  assign q            = state_q[WIDTH-1];
  assign state        = state_q;
  assign wrap         = wrap_q;
  assign lockup       = lock_q;
  assign step_cnt     = cnt_q;
  assign period       = period_q;
  assign period_valid = pvld_q;

endmodule
